// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : PC, IF/ID register, link register and BX stall-marker FSM
// Revision    : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP      = 16'hBF00,
  parameter logic [15:0] BX_MARK  = 16'hBF01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic [2:0]  pc_mux,
  input  logic        flush,
  input  logic        lr_sel,
  input  logic [15:0] im8_pc,
  input  logic [15:0] im11,
  input  logic [15:0] bx_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr_q,
  output logic [15:0] instr_pc_q,
  output logic [15:0] lr_q,
  output logic        bx_wait,
  output logic [15:0] flush_cnt
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    BX_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_d, instr_pc_d, lr_d, flush_cnt_d;
  logic [15:0] rel_base;
  logic [15:0] redirect_pc;

  // Relative branches are taken from the address of the instruction in IF/ID.
  assign rel_base = instr_pc_q + 16'd1;

  always_comb begin
    redirect_pc = pc_q + 16'd1;
    case (pc_mux)
      3'd1:       redirect_pc = rel_base + im8_pc;
      3'd2, 3'd3: redirect_pc = rel_base + im11;
      3'd4:       redirect_pc = bx_target;
      default:    redirect_pc = pc_q + 16'd1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    lr_d        = lr_q;
    flush_cnt_d = flush_cnt;

    if (!stall_in) begin
      if (flush && (flush_cnt != 16'hFFFF))
        flush_cnt_d = flush_cnt + 16'd1;

      case (state_q)
        RUN: begin
          if (pc_mux == 3'd6) begin
            instr_d = BX_MARK;
            state_d = BX_WAIT;
          end else begin
            pc_d = redirect_pc;
            if ((pc_mux == 3'd3) && lr_sel)
              lr_d = rel_base;
            if (flush) begin
              instr_d    = NOP;
              instr_pc_d = redirect_pc;
            end else begin
              instr_d    = imem_rdata;
              instr_pc_d = pc_q;
            end
          end
        end
        BX_WAIT: begin
          // Only the BX redirect releases the wait; anything else holds.
          if (pc_mux == 3'd4) begin
            pc_d    = bx_target;
            instr_d = NOP;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      instr_pc_q <= RESET_PC;
      lr_q       <= 16'h0000;
      flush_cnt  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      lr_q       <= lr_d;
      flush_cnt  <= flush_cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign bx_wait   = (state_q == BX_WAIT);

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipeline, directly upstream of the decode-stage branch unit. It owns the PC, the IF/ID instruction register, and the link register. Each cycle it applies the branch unit's `pc_mux`/`flush` decision for the instruction currently held in IF/ID. It also injects the BX stall marker and retires it with the register target.

## Interface

Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `NOP`, default 16'hBF00: instruction placed in IF/ID on reset and on flush.
- `BX_MARK`, default 16'hBF01: stall marker injected after BX.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_in`  in  1  hazard freeze from the pipeline control.
- `pc_mux`  in  3  next-PC select from the branch unit, combinational from `instr_q`.
- `flush`  in  1  discard the instruction fetched this cycle.
- `lr_sel`  in  1  write LR; used only with `pc_mux`=3.
- `im8_pc`  in  16  sign-extended conditional-branch offset.
- `im11`  in  16  sign-extended B/BL offset.
- `bx_target`  in  16  BX destination from the register read path; valid while `pc_mux`=4.
- `imem_addr`  out  16  instruction-memory address; equals `pc_q`.
- `imem_rdata`  in  16  combinational IMem read data for `imem_addr`.
- `instr_q`  out  16  IF/ID instruction, fed to decode and the branch unit.
- `instr_pc_q`  out  16  address of `instr_q`.
- `lr_q`  out  16  link register.
- `bx_wait`  out  1  high while in state BX_WAIT.
- `flush_cnt`  out  16  saturating count of flush cycles.

## Operation

- Reset values: `pc_q`=RESET_PC, `instr_q`=NOP, `instr_pc_q`=RESET_PC, `lr_q`=0, `flush_cnt`=0, state RUN.
- `bx_wait` is 0 in reset because the state is RUN.
- States: RUN and BX_WAIT. `bx_wait` = (state==BX_WAIT).
- RUN, `stall_in`=0, next PC by `pc_mux`. All adds are 16-bit and wrap modulo 2^16.
  - 0, 5 or 7: `pc_q`+1.
  - 1: `instr_pc_q`+1+`im8_pc`.
  - 2: `instr_pc_q`+1+`im11`.
  - 3: same as 2; additionally `lr_q`<=`instr_pc_q`+1 when `lr_sel`=1.
  - 4: `bx_target`.
  - 6: `pc_q` is held, `instr_q`<=BX_MARK, `instr_pc_q` is held, state goes to BX_WAIT.
- IF/ID update in RUN for `pc_mux`≠6:
  - `flush`=1: `instr_q`<=NOP and `instr_pc_q`<=the next PC.
  - `flush`=0: `instr_q`<=`imem_rdata` and `instr_pc_q`<=`pc_q`.
- BX_WAIT: the branch unit decodes BX_MARK and drives `pc_mux`=4 with `flush`=1.
  - On `pc_mux`=4: `pc_q`<=`bx_target`, `instr_q`<=NOP, state goes to RUN.
  - Any other `pc_mux`: hold all state and remain in BX_WAIT.
- `stall_in`=1, in any state: PC, IF/ID, LR, state and `flush_cnt` are all held, and all redirects are ignored. The branch unit re-presents the same decision once the stall is released.
- `flush_cnt` increments on each unstalled cycle with `flush`=1 and saturates at 16'hFFFF.
- A `flush`=1 with `pc_mux`=0 drops one fetched instruction; the PC advances normally.
- Asserting `rst_n` low mid-operation, including in BX_WAIT, immediately forces all reset values and discards any pending BX.

## Timing

- Fetch-to-decode latency is 1 cycle: the word at `pc_q` appears on `instr_q` at the next edge.
- Taken-branch penalty is 1 bubble: NOP occupies IF/ID for one cycle, and the target instruction reaches `instr_q` 2 edges after the branch was in IF/ID.
- BX penalty is 2 bubbles: BX_MARK for one cycle, then NOP for one cycle. The target instruction reaches `instr_q` 3 edges after BX.
- LR is written on the same edge as the BL redirect.
- `imem_addr` is registered output only, with no combinational path from `pc_mux`.

## Test plan

- Sequential fetch: release reset with IMem[i]=16'h2000+i. `instr_q` shows NOP, then 16'h2000, 16'h2001, 16'h2002 on successive edges; `instr_pc_q` is 0,0,1,2.
- Unconditional branch: `instr_pc_q`=5, drive `pc_mux`=2, `im11`=16'hFFFC, `flush`=1 for one cycle. Next `pc_q`=2, next `instr_q`=NOP, `flush_cnt`=1.
- BL: `instr_pc_q`=16'h0010, drive `pc_mux`=3, `lr_sel`=1, `im11`=16'h0020. Result: `lr_q`=16'h0011 and `pc_q`=16'h0031.
- BX sequence: drive `pc_mux`=6, `flush`=1. `instr_q`=16'hBF01, PC is held and `bx_wait`=1. Next cycle drive `pc_mux`=4 with `bx_target`=16'h0040. Result: `pc_q`=16'h0040, `instr_q`=NOP, `bx_wait`=0.
- Stall and wrap: `pc_q`=16'hFFFF with `stall_in`=1 for 3 cycles while `pc_mux`=1. No state change. On release with `pc_mux`=0, `pc_q`=16'h0000.
- Reset in BX_WAIT: assert `rst_n`=0 asynchronously mid-cycle. Outputs immediately return to reset values and `bx_wait`=0.
